// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the divide and multiply blocks.
package fp_pkg;

   localparam int FP_FRAC_WIDTH = 24;
   localparam int FP_EXP_WIDTH  = 8;
   localparam int FP_BIAS       = (1 << (FP_EXP_WIDTH - 1)) - 1;
   localparam int FP_MAX_EXP    = (1 << FP_EXP_WIDTH) - 1;

   typedef enum logic [2:0] {
      IDLE,
      UNPACK,
      DIVIDE,
      ROUND,
      DONE
   } div_state_e;

   function automatic int fp_bias(input int exp_width);
      return (1 << (exp_width - 1)) - 1;
   endfunction

   function automatic int fp_max_exp(input int exp_width);
      return (1 << exp_width) - 1;
   endfunction

   // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
   // Returned in the low frac_width+exp_width bits of a wide word.
   function automatic logic [63:0] fp_qnan(input int frac_width, input int exp_width);
      logic [63:0] word;
      word = '0;
      for (int i = 0; i < exp_width; i++) begin
         word[frac_width - 1 + i] = 1'b1;
      end
      word[frac_width - 2] = 1'b1;
      return word;
   endfunction

endpackage

// File: rtl/floating_point_classify.sv
// Combinational operand classifier shared by the FP blocks.
module floating_point_classify
   import fp_pkg::*;
#(
   parameter int FRAC_WIDTH = FP_FRAC_WIDTH,
   parameter int EXP_WIDTH  = FP_EXP_WIDTH
) (
   input  logic [FRAC_WIDTH+EXP_WIDTH-1:0] operand_in,
   output logic                            is_zero,
   output logic                            is_subnormal,
   output logic                            is_inf,
   output logic                            is_nan
);

   localparam int W = FRAC_WIDTH + EXP_WIDTH;

   logic [EXP_WIDTH-1:0]  exp_field;
   logic [FRAC_WIDTH-2:0] mant_field;
   logic                  exp_zero;
   logic                  exp_ones;
   logic                  mant_zero;

   assign exp_field  = operand_in[W-2 -: EXP_WIDTH];
   assign mant_field = operand_in[FRAC_WIDTH-2:0];
   assign exp_zero   = (exp_field == '0);
   assign exp_ones   = (exp_field == '1);
   assign mant_zero  = (mant_field == '0);

   assign is_zero      = exp_zero & mant_zero;
   assign is_subnormal = exp_zero & ~mant_zero;
   assign is_inf       = exp_ones & mant_zero;
   assign is_nan       = exp_ones & ~mant_zero;

endmodule

// File: rtl/floating_point_divide.sv
// Multi-cycle IEEE-754 style divider: restoring division, one quotient bit
// per cycle, round to nearest even, subnormals flushed to zero.
module floating_point_divide
   import fp_pkg::*;
#(
   parameter int FRAC_WIDTH = FP_FRAC_WIDTH,
   parameter int EXP_WIDTH  = FP_EXP_WIDTH
) (
   input  logic                            clkIn,
   input  logic                            rstIn,
   input  logic [FRAC_WIDTH+EXP_WIDTH-1:0] dataAIn,
   input  logic [FRAC_WIDTH+EXP_WIDTH-1:0] dataBIn,
   input  logic                            validIn,
   output logic                            readyOut,
   output logic [FRAC_WIDTH+EXP_WIDTH-1:0] dataOut,
   output logic                            validOut,
   input  logic                            readyIn
);

   localparam int W   = FRAC_WIDTH + EXP_WIDTH;
   localparam int M   = FRAC_WIDTH - 1;
   localparam int QW  = FRAC_WIDTH + 2;
   localparam int EW2 = EXP_WIDTH + 2;
   localparam int CW  = $clog2(QW + 1);

   localparam logic signed [EW2-1:0] BIAS_S = EW2'(fp_bias(EXP_WIDTH));
   localparam logic signed [EW2-1:0] MAX_S  = EW2'(fp_max_exp(EXP_WIDTH));
   localparam logic signed [EW2-1:0] ZERO_S = '0;
   localparam logic signed [EW2-1:0] ONE_S  = EW2'(1);
   localparam logic [63:0]           QNAN_WIDE = fp_qnan(FRAC_WIDTH, EXP_WIDTH);
   localparam logic [W-1:0]          QNAN      = QNAN_WIDE[W-1:0];
   localparam logic [CW-1:0]         LAST_ITER = CW'(QW - 1);

   div_state_e              state_q, state_d;
   logic [W-1:0]            op_a_q, op_a_d;
   logic [W-1:0]            op_b_q, op_b_d;
   logic                    sign_q, sign_d;
   logic signed [EW2-1:0]   exp_q, exp_d;
   logic [FRAC_WIDTH:0]     rem_q, rem_d;
   logic [FRAC_WIDTH-1:0]   divisor_q, divisor_d;
   logic [QW-1:0]           quot_q, quot_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    special_q, special_d;
   logic [W-1:0]            result_q, result_d;

   logic a_zero_raw, a_sub, a_inf, a_nan;
   logic b_zero_raw, b_sub, b_inf, b_nan;

   floating_point_classify #(
      .FRAC_WIDTH (FRAC_WIDTH),
      .EXP_WIDTH  (EXP_WIDTH)
   ) u_classify_a (
      .operand_in   (op_a_q),
      .is_zero      (a_zero_raw),
      .is_subnormal (a_sub),
      .is_inf       (a_inf),
      .is_nan       (a_nan)
   );

   floating_point_classify #(
      .FRAC_WIDTH (FRAC_WIDTH),
      .EXP_WIDTH  (EXP_WIDTH)
   ) u_classify_b (
      .operand_in   (op_b_q),
      .is_zero      (b_zero_raw),
      .is_subnormal (b_sub),
      .is_inf       (b_inf),
      .is_nan       (b_nan)
   );

   logic         res_sign;
   logic         a_zero, b_zero;
   logic         is_special;
   logic [W-1:0] special_res;

   // Pick the special-case result (subnormals already count as zero).
   always_comb begin
      res_sign    = op_a_q[W-1] ^ op_b_q[W-1];
      a_zero      = a_zero_raw | a_sub;
      b_zero      = b_zero_raw | b_sub;
      is_special  = 1'b1;
      special_res = '0;
      if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
         special_res = QNAN;
      end else if (a_inf | b_zero) begin
         special_res = {res_sign, {EXP_WIDTH{1'b1}}, {M{1'b0}}};
      end else if (a_zero | b_inf) begin
         special_res = {res_sign, {(W-1){1'b0}}};
      end else begin
         is_special = 1'b0;
      end
   end

   logic                  q_msb;
   logic signed [EW2-1:0] norm_exp;
   logic signed [EW2-1:0] rnd_exp;
   logic [M-1:0]          mant_raw;
   logic                  round_bit;
   logic                  sticky;
   logic                  round_inc;
   logic [M:0]            mant_sum;
   logic [W-1:0]          round_res;

   // Normalize the quotient, round to nearest even and clamp the exponent.
   always_comb begin
      q_msb     = quot_q[QW-1];
      norm_exp  = q_msb ? exp_q : (exp_q - ONE_S);
      mant_raw  = q_msb ? quot_q[QW-2 -: M] : quot_q[QW-3 -: M];
      round_bit = q_msb ? quot_q[1] : quot_q[0];
      sticky    = q_msb ? (quot_q[0] | (|rem_q)) : (|rem_q);
      round_inc = round_bit & (sticky | mant_raw[0]);
      mant_sum  = {1'b0, mant_raw} + {{M{1'b0}}, round_inc};
      rnd_exp   = norm_exp + $signed({{(EW2-1){1'b0}}, mant_sum[M]});
      if (rnd_exp >= MAX_S) begin
         round_res = {sign_q, {EXP_WIDTH{1'b1}}, {M{1'b0}}};
      end else if (rnd_exp <= ZERO_S) begin
         round_res = {sign_q, {(W-1){1'b0}}};
      end else begin
         round_res = {sign_q, rnd_exp[EXP_WIDTH-1:0], mant_sum[M-1:0]};
      end
   end

   logic                ge;
   logic [FRAC_WIDTH:0] diff;

   // Next-state logic and datapath updates for each FSM state.
   always_comb begin
      state_d   = state_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      rem_d     = rem_q;
      divisor_d = divisor_q;
      quot_d    = quot_q;
      cnt_d     = cnt_q;
      special_d = special_q;
      result_d  = result_q;
      ge        = (rem_q >= {1'b0, divisor_q});
      diff      = ge ? (rem_q - {1'b0, divisor_q}) : rem_q;
      case (state_q)
         IDLE: begin
            if (validIn) begin
               op_a_d  = dataAIn;
               op_b_d  = dataBIn;
               state_d = UNPACK;
            end
         end
         UNPACK: begin
            sign_d    = res_sign;
            exp_d     = $signed({2'b00, op_a_q[W-2 -: EXP_WIDTH]})
                      - $signed({2'b00, op_b_q[W-2 -: EXP_WIDTH]}) + BIAS_S;
            rem_d     = {2'b01, op_a_q[M-1:0]};
            divisor_d = {1'b1, op_b_q[M-1:0]};
            quot_d    = '0;
            cnt_d     = '0;
            // Specials are held one extra cycle so their latency is fixed.
            if (special_q) begin
               special_d = 1'b0;
               result_d  = special_res;
               state_d   = DONE;
            end else if (is_special) begin
               special_d = 1'b1;
            end else begin
               state_d = DIVIDE;
            end
         end
         DIVIDE: begin
            rem_d  = {diff[FRAC_WIDTH-1:0], 1'b0};
            quot_d = {quot_q[QW-2:0], ge};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
               cnt_d   = '0;
               state_d = ROUND;
            end
         end
         ROUND: begin
            result_d = round_res;
            state_d  = DONE;
         end
         DONE: begin
            if (readyIn) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset drops any division in progress.
   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         state_q   <= IDLE;
         op_a_q    <= '0;
         op_b_q    <= '0;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         rem_q     <= '0;
         divisor_q <= '0;
         quot_q    <= '0;
         cnt_q     <= '0;
         special_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         sign_q    <= sign_d;
         exp_q     <= exp_d;
         rem_q     <= rem_d;
         divisor_q <= divisor_d;
         quot_q    <= quot_d;
         cnt_q     <= cnt_d;
         special_q <= special_d;
         result_q  <= result_d;
      end
   end

   assign readyOut = (state_q == IDLE);
   assign validOut = (state_q == DONE);
   assign dataOut  = result_q;

endmodule
